// File: rtl/spu_local_store.sv
// Word-addressed local store for the SPU core, with a host image-load port
// that holds the core in reset while a program image streams in.
module spu_local_store #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    input  logic             host_start,
    input  logic             host_valid,
    input  logic [WIDTH-1:0] host_data,
    input  logic             host_last,
    output logic             host_ready,
    output logic             cpu_hold,
    output logic [AW:0]      load_count,
    output logic             err
);

    typedef enum logic [1:0] {HOLD, LOAD, RUN} state_t;

    state_t           state_q;
    logic [AW-1:0]    ptr_q;
    logic [AW:0]      load_count_q;
    logic [WIDTH-1:0] memdata_q;
    logic             err_q;
    logic             cpu_hold_q;
    logic             host_ready_q;

    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];

    logic             in_range;
    logic             host_wr;
    logic             core_wr;
    logic             mem_we;
    logic [AW-1:0]    mem_wadr;
    logic [WIDTH-1:0] mem_wdata;

    // Host and core writes never overlap: the host writes only in LOAD, the core only in RUN.
    always_comb begin
        in_range  = (adr[WIDTH-1:AW] == '0);
        host_wr   = (state_q == LOAD) && host_valid;
        core_wr   = (state_q == RUN) && memwrite && in_range;
        mem_we    = host_wr || core_wr;
        mem_wadr  = host_wr ? ptr_q : adr[AW-1:0];
        mem_wdata = host_wr ? host_data : writedata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wadr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HOLD;
            ptr_q        <= '0;
            load_count_q <= '0;
            memdata_q    <= '0;
            err_q        <= 1'b0;
            cpu_hold_q   <= 1'b1;
            host_ready_q <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (host_start) begin
                        state_q      <= LOAD;
                        ptr_q        <= '0;
                        load_count_q <= '0;
                        host_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (host_valid) begin
                        ptr_q        <= ptr_q + AW'(1);
                        load_count_q <= load_count_q + (AW+1)'(1);
                        if (host_last || ptr_q == '1) begin
                            state_q      <= RUN;
                            host_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (memread && memwrite) begin
                        err_q <= 1'b1;
                    end else if (memread) begin
                        if (in_range) begin
                            memdata_q <= mem_q[adr[AW-1:0]];
                        end else begin
                            memdata_q <= '0;
                            err_q     <= 1'b1;
                        end
                    end else if (memwrite && !in_range) begin
                        err_q <= 1'b1;
                    end
                    if (host_start) begin
                        state_q      <= LOAD;
                        ptr_q        <= '0;
                        load_count_q <= '0;
                        cpu_hold_q   <= 1'b1;
                        host_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= HOLD;
                    cpu_hold_q   <= 1'b1;
                    host_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign memdata    = memdata_q;
    assign host_ready = host_ready_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_count = load_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_spu_local_store.sv
// Directed bench for spu_local_store, built with AW=3 so the store-full case is reachable.
module tb_spu_local_store;

    localparam int WIDTH = 32;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] memdata;
    logic             host_start;
    logic             host_valid;
    logic [WIDTH-1:0] host_data;
    logic             host_last;
    logic             host_ready;
    logic             cpu_hold;
    logic [AW:0]      load_count;
    logic             err;

    int n_total = 0;
    int n_bad   = 0;

    spu_local_store #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .adr        (adr),
        .writedata  (writedata),
        .memdata    (memdata),
        .host_start (host_start),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .cpu_hold   (cpu_hold),
        .load_count (load_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_load();
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        host_valid = 1'b1;
        host_data  = d;
        host_last  = last;
        tick();
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        memread = 1'b1;
        adr     = a;
        tick();
        memread = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    initial begin
        int sent;
        int accepted;
        logic ready_now;
        logic [31:0] img [4];
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;

        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
        host_start = 1'b0; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_hold",  cpu_hold,   1);
        check("rst_ready", host_ready, 0);
        check("rst_count", load_count, 0);
        check("rst_err",   err,        0);
        check("rst_data",  memdata,    0);

        start_load();
        check("start_ready", host_ready, 1);
        check("start_hold",  cpu_hold,   1);
        for (int i = 0; i < 4; i++) begin
            send(img[i], i == 3);
            if (i == 2) check("mid_ready", host_ready, 1);
        end
        check("load4_count", load_count, 4);
        check("load4_hold",  cpu_hold,   0);
        check("load4_ready", host_ready, 0);

        for (int i = 0; i < 4; i++) begin
            rd(i);
            check($sformatf("rd%0d", i), memdata, img[i]);
        end

        wr(5, 32'hDEADBEEF);
        check("wr_keep", memdata, 32'h44);
        rd(5);
        check("rd5", memdata, 32'hDEADBEEF);
        tick();
        check("rd5_hold", memdata, 32'hDEADBEEF);
        check("err_clean", err, 0);

        memread = 1'b1; memwrite = 1'b1; adr = 7; writedata = 32'h5;
        tick();
        memread = 1'b0; memwrite = 1'b0;
        check("both_keep", memdata, 32'hDEADBEEF);
        check("both_err",  err, 1);
        rd(7);
        check("both_rd7", memdata, 32'h5);

        // Out-of-range read from a clean err state; array survives reset.
        do_reset();
        check("rst2_err", err, 0);
        start_load();
        send(32'h77, 1'b1);
        rd(0);
        check("rd0_new", memdata, 32'h77);
        rd(32'd8);
        check("oor_rd_data", memdata, 0);
        check("oor_rd_err",  err, 1);
        tick();
        check("err_sticky", err, 1);

        do_reset();
        start_load();
        send(32'h78, 1'b1);
        wr(32'd11, 32'h999);
        check("oor_wr_err", err, 1);
        rd(3);
        check("oor_wr_mem3", memdata, 32'h44);

        // Store full: 10 words offered every other cycle, no host_last.
        do_reset();
        start_load();
        sent = 0;
        accepted = 0;
        for (int c = 0; c < 30; c++) begin
            ready_now  = host_ready;
            host_valid = (c % 2 == 0) && (sent < 10);
            host_data  = 32'h100 + sent;
            tick();
            if (host_valid && ready_now) begin
                accepted++;
                sent++;
            end else if (host_valid) begin
                sent++;
            end
        end
        host_valid = 1'b0;
        check("full_accepted", accepted, 8);
        check("full_count",    load_count, 8);
        check("full_ready",    host_ready, 0);
        check("full_hold",     cpu_hold, 0);
        rd(0);
        check("full_rd0", memdata, 32'h100);
        rd(7);
        check("full_rd7", memdata, 32'h107);

        // Reset mid-load, then reload restarts at address 0.
        do_reset();
        start_load();
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b0);
        check("part_count", load_count, 2);
        reset = 1'b1;
        host_valid = 1'b1; host_data = 32'hA2;
        tick();
        reset = 1'b0; host_valid = 1'b0;
        check("midrst_hold",  cpu_hold, 1);
        check("midrst_ready", host_ready, 0);
        check("midrst_count", load_count, 0);
        check("midrst_data",  memdata, 0);
        start_load();
        send(32'hB0, 1'b1);
        check("reload_count", load_count, 1);
        rd(0);
        check("reload_rd0", memdata, 32'hB0);
        rd(1);
        check("reload_rd1", memdata, 32'hA1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/spu_local_store.md
# spu_local_store

Word-addressed local store that answers the SPU core's memory interface (memread/memwrite/adr/writedata in, memdata out). It also accepts a program image from a host over a valid/ready stream. While an image is loading it holds the core in reset through `cpu_hold`; once the load completes it releases the core and serves its fetches, loads and stores. It sits beside the core in the SPU top level, and the core's reset is driven by `reset | cpu_hold`.

## Interface
Parameters:
- `WIDTH`, 32, data and address width, matching the core.
- `AW`, 10, log2 of depth in words; depth = 2^AW.

Ports:
- `clk` — input, 1 — clock; all state updates on the rising edge.
- `reset` — input, 1 — synchronous, active-high.
- `memread` — input, 1 — core read request, sampled each edge.
- `memwrite` — input, 1 — core write request, sampled each edge.
- `adr` — input, WIDTH — core word address.
- `writedata` — input, WIDTH — core store data.
- `memdata` — output, WIDTH — registered read data returned to the core.
- `host_start` — input, 1 — request a new image load.
- `host_valid` — input, 1 — host word valid.
- `host_data` — input, WIDTH — host word.
- `host_last` — input, 1 — marks the final word of the image.
- `host_ready` — output, 1 — store accepts a host word this cycle.
- `cpu_hold` — output, 1 — hold the core in reset.
- `load_count` — output, AW+1 — number of words accepted in the current or most recent load.
- `err` — output, 1 — sticky protocol/range error flag.

## Operation
- State machine with three states: HOLD, LOAD, RUN. Reset enters HOLD.
- HOLD:
  - `cpu_hold`=1, `host_ready`=0; core accesses ignored.
  - `host_start`=1 → LOAD; `load_count` and the load pointer are cleared to 0.
- LOAD:
  - `cpu_hold`=1, `host_ready`=1.
  - On `host_valid & host_ready`: mem[ptr] <= `host_data`, ptr and `load_count` increment.
  - Leave for RUN after accepting a word with `host_last`=1, or after accepting the word at ptr = 2^AW−1 (store full).
  - `host_start` is ignored while in LOAD.
- RUN:
  - `cpu_hold`=0, `host_ready`=0.
  - `host_start`=1 → LOAD; `cpu_hold` rises on the next cycle, and the pointer and count are cleared.
- Core access, honoured in RUN only:
  - Address is in range iff `adr[WIDTH-1:AW]`==0.
  - Write: mem[`adr[AW-1:0]`] <= `writedata`.
  - Read: `memdata` <= mem[`adr[AW-1:0]`].
  - Out-of-range read: `memdata` <= 0 and `err` set.
  - Out-of-range write: dropped and `err` set.
  - `memread` & `memwrite` in the same cycle: the write is performed, the read is ignored (`memdata` unchanged), and `err` is set.
- `memdata` holds its value between reads. It is not updated by writes or by host loads.
- `err` is cleared only by `reset`, not by a new load.
- Memory array contents are not reset; they persist across HOLD/LOAD/RUN transitions and are only changed by writes.

## Timing
- Reset values: `memdata`=0, `cpu_hold`=1, `host_ready`=0, `load_count`=0, `err`=0; state=HOLD.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Read latency is 1 cycle: with `memread` asserted in cycle N, `memdata` is valid in cycle N+1 and held until the next accepted read.
- Write: the array is updated at the edge ending cycle N. A read of the same address in cycle N+1 returns the new data in N+2.
- LOAD throughput is 1 word per cycle. `host_ready` falls in the cycle after the terminating word is accepted, and `cpu_hold` falls in that same cycle.
- The HOLD→LOAD transition takes 1 cycle: `host_ready` is first high in the cycle after `host_start` is sampled.
- `host_valid` without `host_ready` is not a handshake; the host must hold its data until it sees `host_ready`.
- Reset mid-LOAD: the next cycle is HOLD with all outputs at reset values. Words already written remain in the array.
- `load_count` saturates at 2^AW. No word is written beyond ptr 2^AW−1; any host words after full are not accepted (`host_ready`=0).

## Test plan
- Reset, then `host_start`, then 4 words 0x11,0x22,0x33,0x44 with `host_last` on the 4th → `load_count`=4; `cpu_hold` falls the cycle after the 4th handshake; core reads of adr 0..3 return 0x11..0x44, each one cycle later.
- RUN: write 0xDEADBEEF to adr 5, read adr 5 the next cycle → `memdata`=0xDEADBEEF one cycle after the read; `memdata` unchanged in the cycles between.
- RUN: read `adr`=2^AW, and write `adr`=2^AW+3 → `memdata`=0, `err`=1 and remains 1; mem[3] is unchanged.
- RUN: `memread` & `memwrite` both high, adr 7, data 0x5 → mem[7]=5, `memdata` keeps its prior value, `err`=1.
- LOAD with `host_valid` toggling every other cycle and AW=3, sending 10 words without `host_last` → exactly 8 words are stored, `load_count`=8, `host_ready` drops, state goes to RUN.
- Assert `reset` after 2 of 5 load words → next cycle `cpu_hold`=1, `host_ready`=0, `load_count`=0; a new load after `host_start` restarts at address 0.
